// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Holds the fetch FSM state encoding and the default reset/trap vectors.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h8000_0100;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential pc+4, redirect target, or trap vector.
// Flags redirect targets that are not word aligned.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
    if (!redirect_valid) begin
      next_pc = pc + INSTR_BYTES;
    end else if (misalign) begin
      next_pc = TRAP_VECTOR;
    end else begin
      next_pc = redirect_target;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner and single-outstanding instruction fetch sequencer.
// Requests from imem, holds the fetched word for decode, and applies redirects.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        misalign_trap,
  output logic [31:0] misalign_tval
);

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] next_pc;
  logic        misalign;

  pc_next_sel #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_sel (
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .next_pc        (next_pc),
    .misalign       (misalign)
  );

  assign imem_req_addr = pc;
  assign if_pc         = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      pc             <= RESET_VECTOR;
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      if_valid       <= 1'b0;
      if_instr       <= 32'h0;
      misalign_trap  <= 1'b0;
      misalign_tval  <= 32'h0;
    end else begin
      misalign_trap <= misalign;
      if (misalign) begin
        misalign_tval <= redirect_target;
      end

      case (state)
        ST_IDLE: begin
          state          <= ST_REQ;
          imem_req_valid <= 1'b1;
          if (redirect_valid) begin
            pc <= next_pc;
          end
        end

        ST_REQ: begin
          if (imem_req_ready) begin
            state          <= ST_WAIT;
            imem_req_valid <= 1'b0;
            // request already in flight: its response must be discarded
            if (redirect_valid) begin
              pc   <= next_pc;
              kill <= 1'b1;
            end
          end else if (redirect_valid) begin
            pc <= next_pc;
          end
        end

        ST_WAIT: begin
          if (imem_rsp_valid) begin
            kill <= 1'b0;
            if (redirect_valid || kill) begin
              if (redirect_valid) begin
                pc <= next_pc;
              end
              state          <= ST_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              if_instr <= imem_rsp_data;
              if_valid <= 1'b1;
              state    <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= next_pc;
            kill <= 1'b1;
          end
        end

        ST_HOLD: begin
          // redirect wins over the decode handshake; next_pc already reflects that
          if (redirect_valid || if_ready) begin
            pc             <= next_pc;
            if_valid       <= 1'b0;
            state          <= ST_REQ;
            imem_req_valid <= 1'b1;
          end
        end

        default: begin
          state          <= ST_IDLE;
          imem_req_valid <= 1'b0;
          if_valid       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: random imem/decode/redirect traffic
// checked against an architectural model of the expected instruction stream.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_trap;
  logic [31:0] misalign_tval;

  pc_fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .misalign_trap  (misalign_trap),
    .misalign_tval  (misalign_tval)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] trap_tval_q[$];
  int unsigned trap_due_q[$];
  logic [31:0] model_tval;
  int          n_hs;
  int unsigned last_hs_cyc;
  bit          rate_chk;

  // imem model
  bit          outst;
  int          lat_cnt;
  logic [31:0] outst_addr;

  // driver configuration
  bit          drv_en = 1'b0;
  bit          mon_en = 1'b0;
  int          rdy_pct, ifr_pct, redir_pct, lat_min, lat_max;
  bit          spur_en;
  int          ifr_low_cnt;
  bit          dr_pending;
  bit          dr_in_wait;
  logic [31:0] dr_target;

  // monitor history
  bit          prev_hold, prev_req_pending;
  logic [31:0] prev_pc, prev_instr, prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_5A3C;
  endfunction

  function automatic logic [31:0] arch_new_pc(input logic [31:0] t);
    return (t % 4 != 0) ? 32'h8000_0100 : t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_q.push_back(32'h8000_0000);
    trap_tval_q.delete();
    trap_due_q.delete();
    model_tval       = 32'h0;
    outst            = 1'b0;
    prev_hold        = 1'b0;
    prev_req_pending = 1'b0;
    last_hs_cyc      = 0;
    dr_pending       = 1'b0;
    ifr_low_cnt      = 0;
  endtask

  task automatic zero_inputs();
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    if_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
    check({tag, "_req_addr"}, imem_req_addr, 32'h8000_0000);
    check({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
    check({tag, "_if_instr"}, if_instr, 32'h0);
    check({tag, "_trap"}, {31'b0, misalign_trap}, 32'h0);
    check({tag, "_tval"}, misalign_tval, 32'h0);
  endtask

  task automatic cfg(input int rdy, input int ifr, input int rd, input int lmin, input int lmax, input bit sp);
    rdy_pct = rdy; ifr_pct = ifr; redir_pct = rd; lat_min = lmin; lat_max = lmax; spur_en = sp;
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int start;
    start = n_hs;
    for (int i = 0; i < budget && n_hs < start + n; i++) @(negedge clk);
    n_chk++;
    if (n_hs < start + n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d handshakes expected %0d", name, n_hs - start, n);
    end
  endtask

  task automatic wait_redirect(input int budget, input string name);
    for (int i = 0; i < budget && dr_pending; i++) @(negedge clk);
    n_chk++;
    if (dr_pending) begin
      n_fail++;
      dr_pending = 1'b0;
      $display("FAIL %s_timeout: redirect never issued", name);
    end
  endtask

  // stimulus driver + imem responder
  initial begin
    forever begin
      @(negedge clk);
      if (drv_en) begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (outst) begin
          if (lat_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(outst_addr);
            outst          = 1'b0;
          end else begin
            lat_cnt--;
          end
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hDEAD_BEEF;
        end

        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        if (dr_pending && (!dr_in_wait || (outst && !imem_req_valid && !if_valid))) begin
          redirect_valid  = 1'b1;
          redirect_target = dr_target;
          dr_pending      = 1'b0;
        end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
          redirect_valid = 1'b1;
          case ($urandom_range(0, 4))
            0:       redirect_target = 32'h8000_0040;
            1:       redirect_target = 32'hFFFF_FFF8;
            2:       redirect_target = $urandom & 32'hFFFF_FFFC;
            3:       redirect_target = $urandom;
            default: redirect_target = 32'h8000_0042;
          endcase
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back(arch_new_pc(redirect_target));
          if (redirect_target % 4 != 0) begin
            trap_tval_q.push_back(redirect_target);
            trap_due_q.push_back(cyc + 1);
          end
        end

        imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
        if (ifr_low_cnt > 0) begin
          if_ready = 1'b0;
          if (if_valid) ifr_low_cnt--;
        end else begin
          if_ready = ($urandom_range(0, 99) < ifr_pct);
        end

        if (imem_req_valid && imem_req_ready) begin
          check("single_outstanding", {31'b0, outst}, 32'h0);
          outst      = 1'b1;
          outst_addr = imem_req_addr;
          lat_cnt    = $urandom_range(lat_min, lat_max);
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (trap_due_q.size() > 0 && trap_due_q[0] == cyc) begin
          check("misalign_trap", {31'b0, misalign_trap}, 32'h1);
          model_tval = trap_tval_q.pop_front();
          void'(trap_due_q.pop_front());
        end else begin
          check("no_extra_trap", {31'b0, misalign_trap}, 32'h0);
        end
        check("misalign_tval", misalign_tval, model_tval);
        check("req_while_presenting", {31'b0, imem_req_valid & if_valid}, 32'h0);

        if (prev_req_pending) begin
          check("req_valid_held", {31'b0, imem_req_valid}, 32'h1);
          check("req_addr_stable", imem_req_addr, prev_addr);
        end
        if (prev_hold) begin
          check("if_valid_held", {31'b0, if_valid}, 32'h1);
          check("if_pc_held", if_pc, prev_pc);
          check("if_instr_held", if_instr, prev_instr);
        end
        prev_req_pending = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr        = imem_req_addr;
        prev_hold        = if_valid && !if_ready && !redirect_valid;
        prev_pc          = if_pc;
        prev_instr       = if_instr;

        if (imem_req_valid && imem_req_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL req_addr: got 0x%08h expected none", imem_req_addr);
          end else begin
            check("req_addr", imem_req_addr, exp_q[0]);
          end
        end

        if (if_valid && if_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL if_pc: got 0x%08h expected none", if_pc);
          end else begin
            e = exp_q.pop_front();
            check("if_pc", if_pc, e);
            check("if_instr", if_instr, mem_word(e));
            exp_q.push_back(e + 32'd4);
          end
          if (rate_chk && last_hs_cyc != 0) check("issue_rate", cyc - last_hs_cyc, 32'd3);
          last_hs_cyc = cyc;
          n_hs++;
        end
      end
    end
  end

  initial begin
    bit found;
    reset = 1'b1;
    zero_inputs();
    n_hs = 0;
    rate_chk = 1'b0;
    dr_in_wait = 1'b0;
    dr_target = 32'h0;
    clear_model();
    cfg(100, 100, 0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    drv_en = 1'b1;

    // zero-wait stream: one instruction every 3 cycles from the reset vector
    rate_chk = 1'b1;
    wait_hs(4, 40, "stream");
    rate_chk = 1'b0;

    // decode stall while holding
    ifr_low_cnt = 5;
    for (int i = 0; i < 40 && ifr_low_cnt > 0; i++) @(negedge clk);
    wait_hs(2, 40, "stall");

    // redirect while waiting for a response
    cfg(100, 100, 0, 2, 2, 1'b0);
    dr_target = 32'h8000_0040; dr_in_wait = 1'b1; dr_pending = 1'b1;
    wait_redirect(40, "redir_wait");
    wait_hs(2, 40, "redir_wait");

    // misaligned redirect traps and refetches from the trap vector
    cfg(100, 100, 0, 0, 1, 1'b0);
    dr_target = 32'h8000_0042; dr_in_wait = 1'b0; dr_pending = 1'b1;
    wait_redirect(40, "misalign");
    wait_hs(2, 40, "misalign");

    // PC wraps past the top of the address space
    dr_target = 32'hFFFF_FFFC; dr_in_wait = 1'b0; dr_pending = 1'b1;
    wait_redirect(40, "wrap");
    wait_hs(3, 40, "wrap");

    // random traffic
    cfg(70, 70, 8, 0, 2, 1'b1);
    repeat (3000) @(negedge clk);

    // reset while a response is outstanding; the late response must be ignored
    cfg(100, 100, 0, 2, 2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #3;
      if (outst && !imem_req_valid && !if_valid) found = 1'b1;
    end
    check("reach_wait", {31'b0, found}, 32'h1);
    drv_en = 1'b0;
    mon_en = 1'b0;
    reset = 1'b1;
    zero_inputs();
    #1;
    check_reset_outputs("reset_in_wait");
    @(negedge clk);
    reset = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    check("post_reset_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("post_reset_req_addr", imem_req_addr, 32'h8000_0000);
    check("post_reset_if_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    #1;
    check("post_reset_if_valid2", {31'b0, if_valid}, 32'h0);
    clear_model();
    mon_en = 1'b1;
    drv_en = 1'b1;
    wait_hs(3, 60, "after_reset");

    drv_en = 1'b0;
    @(negedge clk);
    zero_inputs();
    repeat (3) @(negedge clk);
    check("trap_queue_drained", trap_due_q.size(), 32'h0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
